// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle through an IDLE/RUN/DONE FSM.
// Define DIGIT_SERIAL_ADDSUB_SAT_EN to saturate the result (unsigned) on entry to DONE.
`timescale 1ns / 1ps
module digit_serial_addsub #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sub,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned NDIG = WIDTH / DIGIT;
   localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;

   generate
      if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
         $error("digit_serial_addsub: WIDTH must be >= 1 and a multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
   logic [WIDTH-1:0] acc_q, acc_d, result_q, result_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
`ifdef DIGIT_SERIAL_ADDSUB_SAT_EN
   logic             sub_q, sub_d;
`endif

   logic [DIGIT:0]   dsum;
   logic [WIDTH-1:0] full_sum;
   logic             last_digit;
   logic             msb_ovf;

   always_comb begin
      dsum       = {1'b0, op1_q[DIGIT-1:0]} + {1'b0, op2_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry_q};
      full_sum   = (acc_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
      last_digit = (cnt_q == CntW'(NDIG - 1));
      // Carry into the MSB is a ^ b ^ s at that bit; XOR with carry out gives signed overflow.
      msb_ovf    = op1_q[DIGIT-1] ^ op2_q[DIGIT-1] ^ dsum[DIGIT-1] ^ dsum[DIGIT];
   end

   always_comb begin
      state_d  = state_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      acc_d    = acc_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
`ifdef DIGIT_SERIAL_ADDSUB_SAT_EN
      sub_d    = sub_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               op1_d   = op1;
               op2_d   = sub ? ~op2 : op2;
               carry_d = sub;
               acc_d   = '0;
               cnt_d   = '0;
`ifdef DIGIT_SERIAL_ADDSUB_SAT_EN
               sub_d   = sub;
`endif
               state_d = StRun;
            end
         end
         StRun: begin
            op1_d   = op1_q >> DIGIT;
            op2_d   = op2_q >> DIGIT;
            acc_d   = full_sum;
            carry_d = dsum[DIGIT];
            cnt_d   = cnt_q + 1'b1;
            if (last_digit) begin
               cout_d = dsum[DIGIT];
               ovf_d  = msb_ovf;
`ifdef DIGIT_SERIAL_ADDSUB_SAT_EN
               if (!sub_q && dsum[DIGIT]) begin
                  result_d = '1;
               end else if (sub_q && !dsum[DIGIT]) begin
                  result_d = '0;
               end else begin
                  result_d = full_sum;
               end
`else
               result_d = full_sum;
`endif
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         op1_q    <= '0;
         op2_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef DIGIT_SERIAL_ADDSUB_SAT_EN
         sub_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
`ifdef DIGIT_SERIAL_ADDSUB_SAT_EN
         sub_q    <= sub_d;
`endif
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign result    = result_q;
   assign carry_out = cout_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed bench for digit_serial_addsub with DIGIT = 2, 1 and 8 instances (WIDTH = 8).
`timescale 1ns / 1ps
module tb_digit_serial_addsub;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid  [3];
   logic       in_ready  [3];
   logic       sub_v     [3];
   logic [7:0] op1_v     [3];
   logic [7:0] op2_v     [3];
   logic       out_valid [3];
   logic       out_ready [3];
   logic [7:0] result    [3];
   logic       carry_out [3];
   logic       overflow  [3];

   int total = 0;
   int bad   = 0;
   int lat_exp [3];

   typedef struct packed {
      logic       s;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] r;
      logic       co;
      logic       ov;
   } vec_t;

   vec_t vecs [7];

   always #5 clk = ~clk;

   digit_serial_addsub #(.WIDTH(8), .DIGIT(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .sub(sub_v[0]),
      .op1(op1_v[0]), .op2(op2_v[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .result(result[0]), .carry_out(carry_out[0]), .overflow(overflow[0])
   );

   digit_serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .sub(sub_v[1]),
      .op1(op1_v[1]), .op2(op2_v[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .result(result[1]), .carry_out(carry_out[1]), .overflow(overflow[1])
   );

   digit_serial_addsub #(.WIDTH(8), .DIGIT(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .sub(sub_v[2]),
      .op1(op1_v[2]), .op2(op2_v[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .result(result[2]), .carry_out(carry_out[2]), .overflow(overflow[2])
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] sat_res(input logic s, input logic [7:0] r, input logic co);
`ifdef DIGIT_SERIAL_ADDSUB_SAT_EN
      if (!s && co) return 8'hFF;
      if (s && !co) return 8'h00;
`endif
      return r;
   endfunction

   task automatic do_op(input int d, input vec_t v);
      int lat;
      string t;
      t = $sformatf("d%0d %s %02h,%02h", d, v.s ? "sub" : "add", v.a, v.b);
      @(posedge clk); #1;
      check_eq({t, " in_ready_pre"}, in_ready[d], 1);
      in_valid[d] = 1'b1;
      sub_v[d]    = v.s;
      op1_v[d]    = v.a;
      op2_v[d]    = v.b;
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
      lat = 0;
      while (!out_valid[d] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check_eq({t, " latency"}, lat, lat_exp[d]);
      check_eq({t, " result"}, result[d], sat_res(v.s, v.r, v.co));
      check_eq({t, " carry"}, carry_out[d], v.co);
      check_eq({t, " ovf"}, overflow[d], v.ov);
      @(posedge clk); #1;
      check_eq({t, " in_ready_post"}, in_ready[d], 1);
      check_eq({t, " out_valid_post"}, out_valid[d], 0);
   endtask

   task automatic reset_abort(input int d, input int run_cycles);
      int seen;
      @(posedge clk); #1;
      in_valid[d] = 1'b1;
      sub_v[d]    = 1'b0;
      op1_v[d]    = 8'h12;
      op2_v[d]    = 8'h34;
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
      repeat (run_cycles) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      check_eq($sformatf("d%0d rst in_ready", d), in_ready[d], 1);
      check_eq($sformatf("d%0d rst out_valid", d), out_valid[d], 0);
      check_eq($sformatf("d%0d rst result", d), result[d], 0);
      check_eq($sformatf("d%0d rst carry", d), carry_out[d], 0);
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid[d]) seen = 1;
      end
      check_eq($sformatf("d%0d aborted op silent", d), seen, 0);
   endtask

   initial begin
      int lat;
      lat_exp = '{4, 8, 1};
      vecs[0] = '{s: 1'b0, a: 8'h12, b: 8'h34, r: 8'h46, co: 1'b0, ov: 1'b0};
      vecs[1] = '{s: 1'b0, a: 8'hFF, b: 8'h01, r: 8'h00, co: 1'b1, ov: 1'b0};
      vecs[2] = '{s: 1'b0, a: 8'h7F, b: 8'h01, r: 8'h80, co: 1'b0, ov: 1'b1};
      vecs[3] = '{s: 1'b1, a: 8'h80, b: 8'h01, r: 8'h7F, co: 1'b1, ov: 1'b1};
      vecs[4] = '{s: 1'b1, a: 8'h05, b: 8'h07, r: 8'hFE, co: 1'b0, ov: 1'b0};
      vecs[5] = '{s: 1'b1, a: 8'h07, b: 8'h05, r: 8'h02, co: 1'b1, ov: 1'b0};
      vecs[6] = '{s: 1'b0, a: 8'hA5, b: 8'h5A, r: 8'hFF, co: 1'b0, ov: 1'b0};
      for (int d = 0; d < 3; d++) begin
         in_valid[d]  = 1'b0;
         sub_v[d]     = 1'b0;
         op1_v[d]     = 8'h00;
         op2_v[d]     = 8'h00;
         out_ready[d] = 1'b1;
      end

      #12;
      for (int d = 0; d < 3; d++) begin
         check_eq($sformatf("d%0d reset in_ready", d), in_ready[d], 1);
         check_eq($sformatf("d%0d reset out_valid", d), out_valid[d], 0);
         check_eq($sformatf("d%0d reset result", d), result[d], 0);
         check_eq($sformatf("d%0d reset carry", d), carry_out[d], 0);
         check_eq($sformatf("d%0d reset ovf", d), overflow[d], 0);
      end
      @(posedge clk); #1;
      rst = 1'b0;

      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < 7; i++) begin
            do_op(d, vecs[i]);
         end
      end

      // Back-pressure: hold the result while new operands are offered.
      @(posedge clk); #1;
      in_valid[0] = 1'b1;
      op1_v[0]    = 8'h12;
      op2_v[0]    = 8'h34;
      sub_v[0]    = 1'b0;
      out_ready[0] = 1'b0;
      @(posedge clk); #1;
      op1_v[0] = 8'h33;
      op2_v[0] = 8'h44;
      lat = 0;
      while (!out_valid[0] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check_eq("stall latency", lat, 4);
      repeat (6) begin
         @(posedge clk); #1;
         check_eq("stall result", result[0], 8'h46);
         check_eq("stall out_valid", out_valid[0], 1);
         check_eq("stall in_ready", in_ready[0], 0);
      end
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      check_eq("release in_ready", in_ready[0], 1);
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      check_eq("release accepted", in_ready[0], 0);
      lat = 0;
      while (!out_valid[0] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check_eq("release latency", lat, 4);
      check_eq("release result", result[0], 8'h77);
      check_eq("release carry", carry_out[0], 0);
      @(posedge clk); #1;

      reset_abort(0, 1);
      do_op(0, vecs[6]);
      reset_abort(1, 1);
      do_op(1, vecs[6]);
      reset_abort(2, 0);
      do_op(2, vecs[6]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
